ps2_cmd_sequencer: RTL and testbench
====================================

PS2_CMD_SEQUENCER -- requirements
Module: ps2_cmd_sequencer

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 20000, meaning the cycle count allowed from a tx done to the response byte.
REQ-002 SHALL have parameter MAX_RETRY, default 3, meaning the number of retransmissions per byte before an error is reported.
REQ-003 SHALL have port iClk, input, 1 bit: the single system clock; all logic is on the posedge.
REQ-004 SHALL have port iRstN, input, 1 bit: synchronous, active-low reset.
REQ-005 SHALL have port iLedReq, input, 1 bit: one-cycle pulse requesting an LED update.
REQ-006 SHALL have port iLed, input, 3 bits: {caps, num, scroll} LED state.
REQ-007 SHALL have port iRxValid, input, 1 bit: received-byte strobe from the PS2 device.
REQ-008 SHALL have port iRxData, input, 8 bits: the received byte.
REQ-009 SHALL have port oTx, output, 1 bit: one-cycle transmit request to the PS2 device.
REQ-010 SHALL have port oTxData, output, 8 bits: the byte to transmit.
REQ-011 SHALL have port iTxOk, input, 1 bit: device reports the transmit completed.
REQ-012 SHALL have port iTxFail, input, 1 bit: device reports the transmit failed.
REQ-013 SHALL have port oRxValid, output, 1 bit: forwarded scancode strobe to the translator.
REQ-014 SHALL have port oRxData, output, 8 bits: the forwarded byte.
REQ-015 SHALL have port oBusy, output, 1 bit: high in any state other than IDLE.
REQ-016 SHALL have port oError, output, 1 bit: one-cycle pulse when retries are exhausted.
REQ-017 SHALL have port oLedState, output, 3 bits: the last LED value acknowledged by the keyboard.

Function
REQ-018 States SHALL be RST_TX, RST_WAIT, RST_ACK, RST_BAT, IDLE, LCMD_TX, LCMD_WAIT, LCMD_ACK, LVAL_TX, LVAL_WAIT, LVAL_ACK.
REQ-019 Byte sent per state: RST_TX sends 8'hFF; LCMD_TX sends 8'hED; LVAL_TX sends {5'b0, latched LED value}.
REQ-020 In every *_TX state, oTx SHALL pulse for exactly one cycle with oTxData valid, then move to the matching *_WAIT state; oTxData SHALL hold its value until the next *_TX state.
REQ-021 In *_WAIT, iTxOk SHALL move to the *_ACK state and clear the timeout counter; iTxFail SHALL count as one retry.
REQ-022 In *_ACK, iRxValid with 8'hFA SHALL advance: RST_ACK->RST_BAT, LCMD_ACK->LVAL_TX, LVAL_ACK->IDLE (oLedState <= latched value).
REQ-023 In *_ACK, 8'hFE (resend) SHALL count as one retry.
REQ-024 In RST_BAT, 8'hAA SHALL go to IDLE; 8'hFC SHALL pulse oError and go to IDLE.
REQ-025 Timeout counter (16 bit, saturating): reaching ACK_TIMEOUT in *_WAIT, *_ACK or RST_BAT SHALL count as one retry.
REQ-026 Retry: if retry count < MAX_RETRY, increment the count and return to the current byte's *_TX state (RST_BAT retries RST_TX).
REQ-027 Retry: otherwise pulse oError, clear the retry count and go to IDLE; oLedState SHALL be unchanged.
REQ-028 The retry count SHALL clear on every successful advance.
REQ-029 Pending flag: set by iLedReq in any state; cleared on entry to LCMD_TX.
REQ-030 IDLE with pending SHALL go to LCMD_TX in the next cycle.
REQ-031 iLed SHALL be latched on entry to LCMD_TX; later iLed changes before IDLE SHALL require a new iLedReq.
REQ-032 Bytes FA, FE, AA, FC received in *_ACK/RST_BAT SHALL be consumed and never forwarded.
REQ-033 All other received bytes, and every byte received in IDLE or *_TX/*_WAIT, SHALL be forwarded: oRxValid pulses the cycle after iRxValid, with oRxData = iRxData.
REQ-034 iLedReq coinciding with an error or completion cycle SHALL still set pending (no loss).
REQ-035 iTxOk and iTxFail asserted together SHALL be treated as a fail.

Reset
REQ-036 On iRstN low at a clock edge: state RST_TX, oTx 0, oTxData 8'h00, oRxValid 0, oRxData 8'h00, oError 0, oLedState 3'b000, pending 0, retry and timeout counters 0.
REQ-037 Reset asserted mid-transfer SHALL abandon the transfer with no oError.
REQ-038 After reset release, the 8'hFF command SHALL always be issued first, so oBusy is 1 out of reset.

Verification
REQ-039 Reset release, device returns TxOk, FA, AA -> exactly one oTx with 8'hFF; IDLE; oBusy 0; no oRxValid.
REQ-040 In IDLE, iLedReq with iLed=3'b101, FA after each byte -> oTx bytes ED then 05; oLedState=3'b101; no forwarded bytes.
REQ-041 In LCMD_ACK, rx FE then FA -> ED sent twice, then 05; one retry; success.
REQ-042 No response, MAX_RETRY=3 -> FF sent 4 times at ACK_TIMEOUT spacing; single oError pulse; IDLE.
REQ-043 Rx 8'h1C during LVAL_WAIT, iLedReq during LVAL_ACK -> 1C forwarded one cycle later; a second ED/val sequence follows FA.
REQ-044 iRstN low during LVAL_WAIT -> outputs at reset values next cycle; FF reissued; oLedState 000.

Source files
------------

// File: rtl/ps2_cmd_sequencer.sv
// PS/2 keyboard command sequencer.
// Issues the reset command (FF) out of reset and waits for ACK (FA) and the
// self-test result (AA/FC). It then serves LED update requests with the
// ED + value exchange. Every byte gets MAX_RETRY retransmissions; a retry is
// triggered by a tx failure, a resend (FE) or a response timeout. Bytes that
// the sequencer does not consume go to the scancode translator.
// Ports:
//   iClk, iRstN          clock, synchronous active-low reset
//   iLedReq, iLed        LED update request pulse and {caps,num,scroll}
//   iRxValid, iRxData    received byte from the PS/2 device
//   oTx, oTxData         one-cycle transmit request and byte
//   iTxOk, iTxFail       transmit completion status from the device
//   oRxValid, oRxData    forwarded scancode byte
//   oBusy                high whenever the sequencer is not IDLE
//   oError               one-cycle pulse when retries are exhausted
//   oLedState            last LED value acknowledged by the keyboard
module ps2_cmd_sequencer #(
  parameter int unsigned ACK_TIMEOUT = 20000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       iClk,
  input  logic       iRstN,
  input  logic       iLedReq,
  input  logic [2:0] iLed,
  input  logic       iRxValid,
  input  logic [7:0] iRxData,
  output logic       oTx,
  output logic [7:0] oTxData,
  input  logic       iTxOk,
  input  logic       iTxFail,
  output logic       oRxValid,
  output logic [7:0] oRxData,
  output logic       oBusy,
  output logic       oError,
  output logic [2:0] oLedState
);

  localparam int unsigned TimeoutW = 16;
  localparam int unsigned RetryW   = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [7:0] CmdReset  = 8'hFF;
  localparam logic [7:0] CmdLed    = 8'hED;
  localparam logic [7:0] RspAck    = 8'hFA;
  localparam logic [7:0] RspResend = 8'hFE;
  localparam logic [7:0] RspBatOk  = 8'hAA;
  localparam logic [7:0] RspBatErr = 8'hFC;

  typedef enum logic [3:0] {
    RST_TX, RST_WAIT, RST_ACK, RST_BAT, IDLE,
    LCMD_TX, LCMD_WAIT, LCMD_ACK, LVAL_TX, LVAL_WAIT, LVAL_ACK
  } stateT;

  stateT                state, stateNext, retryTarget, ackState;
  logic                 pending, pendingNext, clearPending;
  logic [2:0]           ledLatch, ledLatchNext, ledStateNext;
  logic [RetryW-1:0]    retryCnt, retryNext;
  logic [TimeoutW-1:0]  timeoutCnt, timeoutNext, timeoutInc;
  logic                 timeoutHit, retryEvent, consume;
  logic                 txNext, rxValidNext, errorNext, busyNext;
  logic [7:0]           txDataNext, rxDataNext;
  logic                 rxAck, rxResend, rxBatOk, rxBatErr, rxSpecial;

  // Response decode and saturating timeout increment
  always_comb begin
    rxAck      = iRxValid && (iRxData == RspAck);
    rxResend   = iRxValid && (iRxData == RspResend);
    rxBatOk    = iRxValid && (iRxData == RspBatOk);
    rxBatErr   = iRxValid && (iRxData == RspBatErr);
    rxSpecial  = rxAck || rxResend || rxBatOk || rxBatErr;
    timeoutInc = (&timeoutCnt) ? timeoutCnt : timeoutCnt + TimeoutW'(1);
    timeoutHit = 32'(timeoutInc) >= ACK_TIMEOUT;
  end

  // Byte group of the current state: where a retry restarts, where tx ok goes
  always_comb begin
    retryTarget = RST_TX;
    ackState    = RST_ACK;
    case (state)
      LCMD_TX, LCMD_WAIT, LCMD_ACK: begin
        retryTarget = LCMD_TX;
        ackState    = LCMD_ACK;
      end
      LVAL_TX, LVAL_WAIT, LVAL_ACK: begin
        retryTarget = LVAL_TX;
        ackState    = LVAL_ACK;
      end
      default: begin
        retryTarget = RST_TX;
        ackState    = RST_ACK;
      end
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    stateNext    = state;
    txNext       = 1'b0;
    txDataNext   = oTxData;
    ledLatchNext = ledLatch;
    ledStateNext = oLedState;
    errorNext    = 1'b0;
    retryNext    = retryCnt;
    timeoutNext  = '0;
    clearPending = 1'b0;
    consume      = 1'b0;
    retryEvent   = 1'b0;

    case (state)
      RST_TX: begin
        txNext     = 1'b1;
        txDataNext = CmdReset;
        stateNext  = RST_WAIT;
      end
      LCMD_TX: begin
        txNext     = 1'b1;
        txDataNext = CmdLed;
        stateNext  = LCMD_WAIT;
      end
      LVAL_TX: begin
        txNext     = 1'b1;
        txDataNext = {5'b0, ledLatch};
        stateNext  = LVAL_WAIT;
      end
      RST_WAIT, LCMD_WAIT, LVAL_WAIT: begin
        timeoutNext = timeoutInc;
        // A simultaneous ok+fail is a fail
        if (iTxFail || timeoutHit) begin
          retryEvent = 1'b1;
        end else if (iTxOk) begin
          stateNext   = ackState;
          timeoutNext = '0;
        end
      end
      RST_ACK, LCMD_ACK, LVAL_ACK: begin
        timeoutNext = timeoutInc;
        consume     = rxSpecial;
        if (rxAck) begin
          retryNext   = '0;
          timeoutNext = '0;
          if (state == RST_ACK) begin
            stateNext = RST_BAT;
          end else if (state == LCMD_ACK) begin
            stateNext = LVAL_TX;
          end else begin
            stateNext    = IDLE;
            ledStateNext = ledLatch;
          end
        end else if (rxResend || timeoutHit) begin
          retryEvent = 1'b1;
        end
      end
      RST_BAT: begin
        timeoutNext = timeoutInc;
        consume     = rxSpecial;
        if (rxBatOk) begin
          stateNext = IDLE;
          retryNext = '0;
        end else if (rxBatErr) begin
          stateNext = IDLE;
          retryNext = '0;
          errorNext = 1'b1;
        end else if (timeoutHit) begin
          retryEvent = 1'b1;
        end
      end
      IDLE: begin
        // LED value is captured only here so retries resend the same value
        if (pending) begin
          stateNext    = LCMD_TX;
          ledLatchNext = iLed;
          clearPending = 1'b1;
        end
      end
      default: stateNext = RST_TX;
    endcase

    if (retryEvent) begin
      if (32'(retryCnt) < MAX_RETRY) begin
        retryNext = retryCnt + RetryW'(1);
        stateNext = retryTarget;
      end else begin
        retryNext = '0;
        errorNext = 1'b1;
        stateNext = IDLE;
      end
    end

    pendingNext = iLedReq || (pending && !clearPending);
    rxValidNext = iRxValid && !consume;
    rxDataNext  = rxValidNext ? iRxData : oRxData;
    busyNext    = (stateNext != IDLE);
  end

  // State and output registers
  always_ff @(posedge iClk) begin
    if (!iRstN) begin
      state      <= RST_TX;
      oTx        <= 1'b0;
      oTxData    <= 8'h00;
      oRxValid   <= 1'b0;
      oRxData    <= 8'h00;
      oError     <= 1'b0;
      oLedState  <= 3'b000;
      oBusy      <= 1'b1;
      pending    <= 1'b0;
      ledLatch   <= 3'b000;
      retryCnt   <= '0;
      timeoutCnt <= '0;
    end else begin
      state      <= stateNext;
      oTx        <= txNext;
      oTxData    <= txDataNext;
      oRxValid   <= rxValidNext;
      oRxData    <= rxDataNext;
      oError     <= errorNext;
      oLedState  <= ledStateNext;
      oBusy      <= busyNext;
      pending    <= pendingNext;
      ledLatch   <= ledLatchNext;
      retryCnt   <= retryNext;
      timeoutCnt <= timeoutNext;
    end
  end

endmodule

// File: tb/tb_ps2_cmd_sequencer.sv
// Scoreboard bench for ps2_cmd_sequencer: a scripted keyboard model answers
// each transmitted byte, expected tx bytes / forwarded bytes / error pulses
// are queued at stimulus time and a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_ps2_cmd_sequencer;

  localparam int unsigned AckTimeout = 40;
  localparam int unsigned MaxRetry   = 3;
  localparam int          WaitBound  = 3 * AckTimeout + 20;

  logic       iClk = 1'b0;
  logic       iRstN, iLedReq, iRxValid, iTxOk, iTxFail;
  logic [2:0] iLed;
  logic [7:0] iRxData;
  logic       oTx, oRxValid, oBusy, oError;
  logic [7:0] oTxData, oRxData;
  logic [2:0] oLedState;

  ps2_cmd_sequencer #(.ACK_TIMEOUT(AckTimeout), .MAX_RETRY(MaxRetry)) dut (
    .iClk(iClk), .iRstN(iRstN), .iLedReq(iLedReq), .iLed(iLed),
    .iRxValid(iRxValid), .iRxData(iRxData), .oTx(oTx), .oTxData(oTxData),
    .iTxOk(iTxOk), .iTxFail(iTxFail), .oRxValid(oRxValid), .oRxData(oRxData),
    .oBusy(oBusy), .oError(oError), .oLedState(oLedState)
  );

  always #5 iClk = ~iClk;

  typedef struct { int cyc; logic [7:0] data; } rxExpT;

  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  int         txCount = 0;
  int         errExpected = 0;
  logic [7:0] txExpQ[$];
  rxExpT      rxExpQ[$];
  int         txCycles[$];
  logic [2:0] ledExp = 3'b000;
  bit         randInject = 0;
  bit         forceFwd = 0;
  int         forceKind = -1;

  always @(posedge iClk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Monitor: every DUT-presented event is matched against the scoreboard
  always @(negedge iClk) begin
    logic [7:0] e;
    rxExpT      r;
    if (oTx) begin
      txCount++;
      txCycles.push_back(cyc);
      if (txExpQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL tx_unexpected: got oTxData=%h, required no transmit", oTxData);
      end else begin
        e = txExpQ.pop_front();
        check("tx_byte", 32'(oTxData), 32'(e));
      end
      check("led_state_at_tx", 32'(oLedState), 32'(ledExp));
    end
    if (oRxValid) begin
      if (rxExpQ.size() == 0) begin
        checks++; errors++;
        $display("FAIL rx_unexpected: got oRxData=%h, required no forward", oRxData);
      end else begin
        r = rxExpQ.pop_front();
        check("rx_data", 32'(oRxData), 32'(r.data));
        check("rx_cycle", 32'(cyc), 32'(r.cyc));
      end
    end
    if (oError) begin
      checks++;
      if (errExpected == 0) begin
        errors++;
        $display("FAIL error_unexpected: got oError=1, required 0");
      end else begin
        errExpected--;
      end
    end
  end

  task automatic tick();
    @(posedge iClk);
    #1;
  endtask

  function automatic logic [7:0] randPlain();
    logic [7:0] b;
    b = 8'($urandom);
    while (b == 8'hFA || b == 8'hFE || b == 8'hAA || b == 8'hFC) b = 8'($urandom);
    return b;
  endfunction

  function automatic int pickFails();
    int r;
    r = int'($urandom_range(0, 9));
    if (r < 5) return 0;
    if (r < 7) return 1;
    if (r < 8) return 2;
    if (r < 9) return 3;
    return 4;
  endfunction

  task automatic pulseReq();
    iLedReq = 1'b1; tick(); iLedReq = 1'b0;
  endtask

  task automatic pulseRx(input logic [7:0] d, input bit req);
    iRxValid = 1'b1; iRxData = d; iLedReq = req;
    tick();
    iRxValid = 1'b0; iLedReq = 1'b0;
  endtask

  task automatic pulseFwd(input logic [7:0] d);
    rxExpT r;
    r.cyc = cyc + 1; r.data = d;
    rxExpQ.push_back(r);
    pulseRx(d, 1'b0);
  endtask

  task automatic pulseTxResp(input bit ok, input bit fail, input bit req);
    iTxOk = ok; iTxFail = fail; iLedReq = req;
    tick();
    iTxOk = 1'b0; iTxFail = 1'b0; iLedReq = 1'b0;
  endtask

  task automatic waitTx(output bit got);
    int start;
    start = txCount;
    got = 0;
    for (int i = 0; i < WaitBound; i++) begin
      if (txCount != start) begin got = 1; break; end
      tick();
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL tx_wait: no oTx within %0d cycles, required a transmit", WaitBound);
    end
  endtask

  // Failure kinds: 0 tx fail, 1 ok+fail together, 2 ok then FE, 3 silence in wait, 4 ok then silence
  task automatic doFail(input int kind, input bit req, input logic [2:0] nextLed);
    if (req) iLed = nextLed;
    case (kind)
      0: pulseTxResp(1'b0, 1'b1, req);
      1: pulseTxResp(1'b1, 1'b1, req);
      2: begin pulseTxResp(1'b1, 1'b0, 1'b0); pulseRx(8'hFE, req); end
      3: if (req) pulseReq();
      default: pulseTxResp(1'b1, 1'b0, req);
    endcase
  endtask

  // One byte with nFail failed attempts; more than MaxRetry failures ends in an error
  task automatic doByte(input logic [7:0] b, input int nFail, input bit req,
                        input logic [2:0] nextLed, output bit ok);
    bit willFail;
    int attempts;
    bit got;
    int kind;
    int sel;
    willFail = nFail > int'(MaxRetry);
    attempts = willFail ? int'(MaxRetry) + 1 : nFail + 1;
    ok = 0;
    for (int a = 0; a < attempts; a++) begin
      txExpQ.push_back(b);
      waitTx(got);
      if (!got) return;
      if (a == attempts - 1 && !willFail) begin
        if (forceFwd) pulseFwd(8'h1C);
        else if (randInject && $urandom_range(0, 1) == 1) pulseFwd(randPlain());
        pulseTxResp(1'b1, 1'b0, 1'b0);
        if (randInject && $urandom_range(0, 2) == 0) begin
          sel = int'($urandom_range(0, 2));
          if (sel == 0) pulseFwd(randPlain());
          else pulseRx(sel == 1 ? 8'hAA : 8'hFC, 1'b0);
        end
        if (req) iLed = nextLed;
        pulseRx(8'hFA, req);
        ok = 1;
      end else begin
        kind = (forceKind >= 0) ? forceKind : int'($urandom_range(0, 4));
        if (a == attempts - 1) errExpected++;
        doFail(kind, req && (a == attempts - 1), nextLed);
      end
    end
    if (willFail) begin
      for (int i = 0; i < WaitBound && errExpected != 0; i++) tick();
      check("error_pulse_seen", 32'(errExpected == 0), 32'd1);
      errExpected = 0;
    end
  endtask

  task automatic applyReset(input int n);
    iRstN = 1'b0;
    tick();
    txExpQ.delete(); rxExpQ.delete();
    errExpected = 0; ledExp = 3'b000;
    check("rst_oTx", 32'(oTx), 32'd0);
    check("rst_oTxData", 32'(oTxData), 32'h00);
    check("rst_oRxValid", 32'(oRxValid), 32'd0);
    check("rst_oRxData", 32'(oRxData), 32'h00);
    check("rst_oError", 32'(oError), 32'd0);
    check("rst_oLedState", 32'(oLedState), 32'd0);
    check("rst_oBusy", 32'(oBusy), 32'd1);
    for (int i = 1; i < n; i++) tick();
    iRstN = 1'b1;
  endtask

  task automatic resetSeq(input int nFail, input logic [7:0] bat);
    bit ok;
    doByte(8'hFF, nFail, 1'b0, 3'b000, ok);
    if (ok) begin
      if (bat == 8'hFC) errExpected++;
      pulseRx(bat, 1'b0);
    end
    tick(); tick();
    check("reset_seq_idle", 32'(oBusy), 32'd0);
    check("reset_seq_err_done", 32'(errExpected), 32'd0);
  endtask

  task automatic doLed(input logic [2:0] v, input bit pendIn, input bit reqNext,
                       input logic [2:0] nextLed, input int f1, input int f2);
    bit ok;
    if (!pendIn) begin iLed = v; pulseReq(); end
    doByte(8'hED, f1, reqNext && (f1 > int'(MaxRetry)), nextLed, ok);
    if (ok) begin
      iLed = 3'($urandom);
      doByte({5'b0, v}, f2, reqNext, nextLed, ok);
      if (ok) ledExp = v;
    end
    if (!reqNext) begin
      tick(); tick();
      check("led_idle_busy", 32'(oBusy), 32'd0);
      check("led_state", 32'(oLedState), 32'(ledExp));
    end
  endtask

  initial begin
    bit         pend;
    bit         rq;
    bit         got;
    logic [2:0] v, nv;
    iRstN = 1'b0; iLedReq = 1'b0; iLed = 3'b000; iRxValid = 1'b0;
    iRxData = 8'h00; iTxOk = 1'b0; iTxFail = 1'b0;

    // Power-up: FF, TxOk, FA, AA
    applyReset(3);
    resetSeq(0, 8'hAA);

    // Plain LED update, then one FE on the command byte
    doLed(3'b101, 1'b0, 1'b0, 3'b000, 0, 0);
    check("led_101", 32'(oLedState), 32'h5);
    forceKind = 2;
    doLed(3'b101, 1'b0, 1'b0, 3'b000, 1, 0);
    forceKind = -1;

    // Forward during wait, request coinciding with completion
    forceFwd = 1;
    doLed(3'b011, 1'b0, 1'b1, 3'b110, 0, 0);
    forceFwd = 0;
    doLed(3'b110, 1'b1, 1'b0, 3'b000, 0, 0);
    check("led_110", 32'(oLedState), 32'h6);

    // Failed self-test
    applyReset(2);
    resetSeq(0, 8'hFC);
    check("bat_fail_led", 32'(oLedState), 32'd0);

    // Silent keyboard: FF four times, then one error
    applyReset(2);
    txCycles.delete();
    forceKind = 3;
    resetSeq(4, 8'hAA);
    forceKind = -1;
    check("ff_count", 32'(txCycles.size()), 32'd4);
    for (int i = 1; i < txCycles.size(); i++)
      check("ff_spacing", 32'(txCycles[i] - txCycles[i-1] >= int'(AckTimeout) &&
                              txCycles[i] - txCycles[i-1] <= int'(AckTimeout) + 2), 32'd1);

    // Randomized traffic
    applyReset(2);
    randInject = 1;
    resetSeq(int'($urandom_range(0, 3)), 8'hAA);
    pend = 0;
    v = 3'($urandom);
    for (int it = 0; it < 30; it++) begin
      rq = ($urandom_range(0, 3) == 0);
      nv = 3'($urandom);
      doLed(v, pend, rq, nv, pickFails(), pickFails());
      pend = rq;
      v = rq ? nv : 3'($urandom);
    end
    if (pend) doLed(v, 1'b1, 1'b0, 3'b000, 0, 0);
    randInject = 0;

    // Reset in the middle of the value byte
    iLed = 3'b010;
    pulseReq();
    txExpQ.push_back(8'hED);
    waitTx(got);
    pulseTxResp(1'b1, 1'b0, 1'b0);
    pulseRx(8'hFA, 1'b0);
    txExpQ.push_back(8'h02);
    waitTx(got);
    applyReset(1);
    resetSeq(0, 8'hAA);
    check("post_reset_led", 32'(oLedState), 32'd0);

    repeat (5) tick();
    check("tx_queue_drained", 32'(txExpQ.size()), 32'd0);
    check("rx_queue_drained", 32'(rxExpQ.size()), 32'd0);
    check("errors_drained", 32'(errExpected), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
